// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and byte-placement helpers for the data-memory controller.
package mem_pkg;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef enum logic [1:0] {IDLE, A1, A2, RESP} state_t;

  function automatic int size_bytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  // Address-order index of the access byte that lands in a lane; ph=1 is the second word.
  function automatic int byte_pos(input int lane, input int off, input int lanes, input logic ph);
    return ph ? lane + lanes - off : lane - off;
  endfunction

  function automatic logic lane_hit(input int lane, input int off, input int lanes,
                                    input int n, input logic ph);
    int k;
    k = byte_pos(lane, off, lanes, ph);
    return (k >= 0) && (k < n);
  endfunction

  // Significance of an address-order byte inside the right-justified value.
  function automatic int val_byte(input int k, input int n, input logic big);
    return big ? n - 1 - k : k;
  endfunction
endpackage

// File: rtl/data_mem_ctrl_if.sv
// CPU-side request/response bus of the data-memory controller.
interface data_mem_ctrl_if #(parameter int LANES = 4, parameter int WORD_AW = 10);
  localparam int DATA_W = 8 * LANES;
  localparam int AW     = WORD_AW + $clog2(LANES);

  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sext;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              valid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output req, we, size, sext, addr, wdata, input ready, valid, rdata, err);
  modport slave  (input req, we, size, sext, addr, wdata, output ready, valid, rdata, err);
endinterface

// File: rtl/mem_bank.sv
// Byte-wide single-port synchronous RAM; read data appears one cycle after the address.
module mem_bank #(parameter int WORD_AW = 10) (
  input  logic               clk,
  input  logic               we,
  input  logic [WORD_AW-1:0] addr,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata
);
  logic [7:0] mem [1<<WORD_AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: byte/half/word loads and stores over LANES byte banks,
// with boundary-crossing accesses split into two word cycles.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int LANES          = 4,
  parameter int WORD_AW        = 10,
  parameter bit BIG_END        = 1'b1,
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  data_mem_ctrl_if.slave bus
);
  localparam int OFF_W  = $clog2(LANES);
  localparam int DATA_W = 8 * LANES;

  state_t                   state, state_nx;
  logic                     r_we, r_sext, r_err, r_cross;
  logic [1:0]               r_size;
  logic [OFF_W-1:0]         r_off;
  logic [WORD_AW-1:0]       r_wi, bank_a;
  logic [DATA_W-1:0]        r_wdata, rdata_q, ld;
  logic [LANES-1:0]         bank_we;
  logic [LANES-1:0][7:0]    bank_d, bank_q, asm_q, cap, lbytes;
  logic                     accept, in_cross, in_err, ph, sign;
  int                       n, in_n, off;

  always_comb begin
    in_n     = size_bytes(bus.size);
    in_cross = (int'(bus.addr[OFF_W-1:0]) + in_n) > LANES;
    in_err   = (bus.size == SIZE_X) || (!ALLOW_MISALIGN && in_cross);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // ready is also high in RESP so a new request can overlap the completion pulse
  always_comb begin
    state_nx  = state;
    bus.ready = 1'b0;
    bus.valid = 1'b0;
    bus.err   = 1'b0;
    case (state)
      IDLE: bus.ready = 1'b1;
      A1:   state_nx = r_cross ? A2 : RESP;
      A2:   state_nx = RESP;
      RESP: begin
        bus.ready = 1'b1;
        bus.valid = 1'b1;
        bus.err   = r_err;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    accept = bus.ready && bus.req;
    if (accept) state_nx = in_err ? RESP : A1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      if (accept) begin
        r_we    <= bus.we;
        r_size  <= bus.size;
        r_sext  <= bus.sext;
        r_off   <= bus.addr[OFF_W-1:0];
        r_wi    <= bus.addr[OFF_W +: WORD_AW];
        r_wdata <= bus.wdata;
        r_err   <= in_err;
        r_cross <= in_cross;
      end
      if (state == A2) asm_q <= cap;
      if (state == RESP && !r_we && !r_err) rdata_q <= ld;
    end
  end

  // Write enables are gated by rst_n so a reset edge during A2 leaves the second word intact
  always_comb begin
    ph      = (state == A2);
    n       = size_bytes(r_size);
    off     = int'(r_off);
    bank_a  = ph ? r_wi + 1'b1 : r_wi;
    bank_we = '0;
    bank_d  = '0;
    for (int o = 0; o < LANES; o++) begin
      if (lane_hit(o, off, LANES, n, ph)) begin
        bank_we[o] = r_we && rst_n && (state == A1 || state == A2);
        bank_d[o]  = r_wdata[8*val_byte(byte_pos(o, off, LANES, ph), n, BIG_END) +: 8];
      end
    end
  end

  // cap collects first-word bytes during A2; lbytes overlays the last word read on top
  always_comb begin
    cap    = asm_q;
    lbytes = asm_q;
    for (int o = 0; o < LANES; o++) begin
      if (lane_hit(o, off, LANES, n, 1'b0))
        cap[OFF_W'(val_byte(byte_pos(o, off, LANES, 1'b0), n, BIG_END))] = bank_q[o];
      if (lane_hit(o, off, LANES, n, r_cross))
        lbytes[OFF_W'(val_byte(byte_pos(o, off, LANES, r_cross), n, BIG_END))] = bank_q[o];
    end
    sign = r_sext && lbytes[OFF_W'(n - 1)][7];
    ld   = '0;
    for (int j = 0; j < LANES; j++)
      ld[8*j +: 8] = (j < n) ? lbytes[j] : {8{sign}};
  end

  assign bus.rdata = (state == RESP && !r_we && !r_err) ? ld : rdata_q;

  for (genvar g = 0; g < LANES; g++) begin : g_bank
    mem_bank #(.WORD_AW(WORD_AW)) u_bank (
      .clk   (clk),
      .we    (bank_we[g]),
      .addr  (bank_a),
      .wdata (bank_d[g]),
      .rdata (bank_q[g])
    );
  end
endmodule
